// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: valid/ready handshake, one-entry skid buffer, synchronous flush.
// Optional macro ID_EX_PERF_CNT_EN adds saturating stallCnt/bubbleCnt outputs.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_num1,
    input  logic [DATA_W-1:0] id_num2,
    input  logic              id_regWriteEn,
    input  logic [ADDR_W-1:0] id_regWriteAddr,
    input  logic [OP_W-1:0]   id_aluOp,
    input  logic [DATA_W-1:0] id_linkAddr,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_num1,
    output logic [DATA_W-1:0] ex_num2,
    output logic              ex_regWriteEn,
    output logic [ADDR_W-1:0] ex_regWriteAddr,
    output logic [OP_W-1:0]   ex_aluOp,
    output logic [DATA_W-1:0] ex_linkAddr
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       stallCnt,
    output logic [31:0]       bubbleCnt
`endif
);

    localparam int PAY_W = 3 * DATA_W + ADDR_W + OP_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ex_valid;
    logic               r_id_ready;
    logic [PAY_W-1:0]   r_main_pay;
    logic               r_main_we;
    logic [PAY_W-1:0]   r_skid_pay;
    logic               r_skid_we;
    logic [PAY_W-1:0]   w_id_pay;
    logic               w_ld_main_id;
    logic               w_ld_main_skid;
    logic               w_ld_skid;
    logic               w_clr_main;

    assign w_id_pay = {id_num1, id_num2, id_linkAddr, id_regWriteAddr, id_aluOp};

    // Next-state and load-enable decode; flush overrides every transfer.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_id   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        w_clr_main     = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_clr_main  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (id_valid) begin
                        w_ld_main_id = 1'b1;
                        w_state_nxt  = ST_FULL;
                    end else begin
                        w_state_nxt  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (ex_ready) begin
                        if (id_valid) begin
                            w_ld_main_id = 1'b1;
                            w_state_nxt  = ST_FULL;
                        end else begin
                            w_clr_main   = 1'b1;
                            w_state_nxt  = ST_EMPTY;
                        end
                    end else begin
                        if (id_valid) begin
                            w_ld_skid   = 1'b1;
                            w_state_nxt = ST_SKID;
                        end else begin
                            w_state_nxt = ST_FULL;
                        end
                    end
                end
                ST_SKID: begin
                    if (ex_ready) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = ST_FULL;
                    end else begin
                        w_state_nxt    = ST_SKID;
                    end
                end
                default: begin
                    w_clr_main  = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State plus the valid/ready flags, registered so id_ready never sees ex_ready combinationally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_EMPTY;
            r_ex_valid <= 1'b0;
            r_id_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_ex_valid <= (w_state_nxt != ST_EMPTY);
            r_id_ready <= (w_state_nxt != ST_SKID);
        end
    end

    // Main register; payload holds its last value when the entry is retired or flushed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_main_pay <= {PAY_W{1'b0}};
            r_main_we  <= 1'b0;
        end else if (w_ld_main_id) begin
            r_main_pay <= w_id_pay;
            r_main_we  <= id_regWriteEn;
        end else if (w_ld_main_skid) begin
            r_main_pay <= r_skid_pay;
            r_main_we  <= r_skid_we;
        end else if (w_clr_main) begin
            r_main_we  <= 1'b0;
        end else begin
            r_main_we  <= r_main_we;
        end
    end

    // Skid register; its validity is tracked by the SKID state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_skid_pay <= {PAY_W{1'b0}};
            r_skid_we  <= 1'b0;
        end else if (w_ld_skid) begin
            r_skid_pay <= w_id_pay;
            r_skid_we  <= id_regWriteEn;
        end else begin
            r_skid_we  <= r_skid_we;
        end
    end

    assign id_ready      = r_id_ready;
    assign ex_valid      = r_ex_valid;
    assign ex_regWriteEn = r_main_we;
    assign {ex_num1, ex_num2, ex_linkAddr, ex_regWriteAddr, ex_aluOp} = r_main_pay;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Saturating performance counters, cleared only by rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (r_ex_valid && !ex_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!r_ex_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stallCnt  = r_stall_cnt;
    assign bubbleCnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed test-plan sequences plus random traffic
// compared each cycle against a queue-based reference model.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_num1, id_num2, id_linkAddr;
    logic        id_regWriteEn;
    logic [4:0]  id_regWriteAddr;
    logic [3:0]  id_aluOp;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_num1, ex_num2, ex_linkAddr;
    logic        ex_regWriteEn;
    logic [4:0]  ex_regWriteAddr;
    logic [3:0]  ex_aluOp;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stallCnt, bubbleCnt;
`endif

    typedef struct packed {
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] link;
        logic [4:0]  addr;
        logic [3:0]  op;
        logic        we;
    } ent_t;

    ent_t        q[$];
    ent_t        last_e;
    ent_t        cur_in;
    logic [31:0] m_stall, m_bubble;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(32), .ADDR_W(5), .OP_W(4)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_num1(id_num1), .id_num2(id_num2),
        .id_regWriteEn(id_regWriteEn), .id_regWriteAddr(id_regWriteAddr),
        .id_aluOp(id_aluOp), .id_linkAddr(id_linkAddr),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_num1(ex_num1), .ex_num2(ex_num2),
        .ex_regWriteEn(ex_regWriteEn), .ex_regWriteAddr(ex_regWriteAddr),
        .ex_aluOp(ex_aluOp), .ex_linkAddr(ex_linkAddr)
`ifdef ID_EX_PERF_CNT_EN
        , .stallCnt(stallCnt), .bubbleCnt(bubbleCnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_e   = '0;
        m_stall  = 32'd0;
        m_bubble = 32'd0;
    endtask

    // Reference behaviour: an ordered queue of at most two held entries.
    task automatic model_step();
        int  sz;
        bit  accept;
        sz = q.size();
        if (sz != 0 && !ex_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (sz == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 32'd1;
        if (flush) begin
            q.delete();
        end else begin
            accept = id_valid && (sz < 2);
            if (sz != 0 && ex_ready) void'(q.pop_front());
            if (accept) q.push_back(cur_in);
        end
        if (q.size() != 0) last_e = q[0];
    endtask

    task automatic check_all();
        bit v;
        v = (q.size() != 0);
        check_eq("ex_valid", {31'd0, ex_valid}, {31'd0, v});
        check_eq("id_ready", {31'd0, id_ready}, {31'd0, (q.size() < 2)});
        check_eq("ex_num1", ex_num1, last_e.n1);
        check_eq("ex_num2", ex_num2, last_e.n2);
        check_eq("ex_linkAddr", ex_linkAddr, last_e.link);
        check_eq("ex_regWriteAddr", {27'd0, ex_regWriteAddr}, {27'd0, last_e.addr});
        check_eq("ex_aluOp", {28'd0, ex_aluOp}, {28'd0, last_e.op});
        check_eq("ex_regWriteEn", {31'd0, ex_regWriteEn}, {31'd0, (v & last_e.we)});
`ifdef ID_EX_PERF_CNT_EN
        check_eq("stallCnt", stallCnt, m_stall);
        check_eq("bubbleCnt", bubbleCnt, m_bubble);
`endif
    endtask

    // Drive one cycle of inputs (called just after a negedge), step model at posedge, check at negedge.
    task automatic do_cycle(input logic v, input logic r, input logic f, input logic [31:0] n1);
        ent_t e;
        e.n1   = n1;
        e.n2   = $urandom;
        e.link = $urandom;
        e.addr = 5'($urandom);
        e.op   = 4'($urandom);
        e.we   = 1'($urandom);
        cur_in = e;
        id_valid = v; ex_ready = r; flush = f;
        id_num1 = e.n1; id_num2 = e.n2; id_linkAddr = e.link;
        id_regWriteAddr = e.addr; id_aluOp = e.op; id_regWriteEn = e.we;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Reset pulse fully between edges; outputs must clear before the next posedge.
    task automatic async_reset_pulse();
        #2 rstn = 1'b0;
        #1 model_reset();
        check_all();
        #1 rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
        id_num1 = 32'd0; id_num2 = 32'd0; id_linkAddr = 32'd0;
        id_regWriteEn = 1'b0; id_regWriteAddr = 5'd0; id_aluOp = 4'd0;
        cur_in = '0;
        model_reset();
        @(negedge clk);
        check_all();
        rstn = 1'b1;

        // Continuous flow.
        for (int i = 1; i <= 8; i++) do_cycle(1'b1, 1'b1, 1'b0, 32'(i));
        do_cycle(1'b0, 1'b1, 1'b0, 32'd0);

        // Stall into skid and drain.
        do_cycle(1'b1, 1'b0, 1'b0, 32'h11);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h22);
        check_eq("skid_hold_a", ex_num1, 32'h11);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h33);
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("skid_b_out", ex_num1, 32'h22);
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Flush while in SKID with id_valid high.
        do_cycle(1'b1, 1'b0, 1'b0, 32'h44);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h55);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h66);
        check_eq("flush_valid", {31'd0, ex_valid}, 32'd0);
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Bubbles keep the last data.
        do_cycle(1'b1, 1'b1, 1'b0, 32'h77);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("bubble_hold", ex_num1, 32'h77);

        // Async reset pulsed mid-cycle in SKID, then one transfer.
        do_cycle(1'b1, 1'b0, 1'b0, 32'h88);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h99);
        async_reset_pulse();
        do_cycle(1'b1, 1'b1, 1'b0, 32'h5A);
        check_eq("post_reset_5a", ex_num1, 32'h5A);

        // Stall cycles, empty cycles, then flush (counters must survive flush).
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b0, 32'hA0);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199, 0) == 0) async_reset_pulse();
            do_cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(2, 0) != 0),
                     1'($urandom_range(15, 0) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
